// File: rtl/link_pkg.sv
// Shared types and defaults for the link scheduler.
//   state_t    : exchange FSM states
//   ERR_*      : err_code values reported on err
//   *_DEF      : default frame length, frames per phase, idle timeout
package link_pkg;

  localparam int unsigned PKT_BITS_DEF = 21;
  localparam int unsigned PKTS_DEF     = 8;
  localparam int unsigned TIMEOUT_DEF  = 1024;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DOWN    = 3'd1,
    TURN    = 3'd2,
    UP      = 3'd3,
    WAIT_WB = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/frame_mon.sv
// Serial frame monitor: counts consecutive sen-low cycles, captures the
// 3-bit address from sd in low cycles 1..3 (MSB first) and classifies the
// frame when sen returns idle.
//   clk, rst   : clock, synchronous active-high reset
//   sen, sd    : monitored serial enable (0 = frame bit) and data
//   sen_idle   : sen is not a frame bit this cycle
//   sen_edge   : sen changed between low and idle versus the previous sample
//   len_ok     : frame ends this edge with exactly PKT_BITS low cycles
//   len_short  : frame ends this edge with fewer than PKT_BITS low cycles
//   len_long   : sen still low with PKT_BITS cycles already counted
//   addr       : captured frame address
module frame_mon
  import link_pkg::*;
#(
  parameter int unsigned PKT_BITS = PKT_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sen,
  input  logic       sd,
  output logic       sen_idle,
  output logic       sen_edge,
  output logic       len_ok,
  output logic       len_short,
  output logic       len_long,
  output logic [2:0] addr
);

  localparam int unsigned CW = $clog2(PKT_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(PKT_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(PKT_BITS + 1);

  logic [CW-1:0] cnt;
  logic          sen_low;
  logic          was_low;

  // Only an explicit 0 marks a frame bit; X/Z count as idle.
  assign sen_low  = (sen === 1'b0);
  assign sen_idle = !sen_low;

  // cnt saturates above zero, so a non-zero count doubles as the previous
  // sen sample and no separate edge register is needed.
  assign was_low  = (cnt != '0);
  assign sen_edge = sen_low ^ was_low;

  assign len_ok    = sen_idle && (cnt == CNT_FULL);
  assign len_short = sen_idle && was_low && (cnt < CNT_FULL);
  assign len_long  = sen_low && (cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      addr <= '0;
    end else if (sen_low) begin
      if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      if (cnt < CW'(3)) addr <= {addr[1:0], sd};
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/link_sched.sv
// Link scheduler: runs one down (buffer unit transmits) then up (buffer unit
// receives) exchange of PKTS serial frames each, checking frame length,
// address order and per-phase idle timeout, then waits for write-back.
//   clk, rst   : clock, synchronous active-high reset
//   start      : single-cycle exchange request (honoured in IDLE/DONE/ERR)
//   sen, sd    : monitored serial enable and data
//   s1_done    : write-back complete level from the buffer-side unit
//   updown     : 0 = buffer unit transmits, 1 = buffer unit receives
//   busy, done : exchange running / completed OK
//   err        : exchange aborted; err_code 1 length, 2 address, 3 timeout
//   pkt_cnt    : good frames in current phase; last_addr: last good address
module link_sched
  import link_pkg::*;
#(
  parameter int unsigned PKT_BITS = PKT_BITS_DEF,
  parameter int unsigned PKTS     = PKTS_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sen,
  input  logic       sd,
  input  logic       s1_done,
  output logic       updown,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [3:0] pkt_cnt,
  output logic [2:0] last_addr
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT - 1);
  localparam logic [3:0]    PKTS_L  = 4'(PKTS);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmr;
  logic          turn_idle;
  logic          sen_idle;
  logic          sen_edge;
  logic          len_ok;
  logic          len_short;
  logic          len_long;
  logic [2:0]    addr;
  logic [1:0]    code_nxt;
  logic          updown_nxt;
  logic          pkt_inc;
  logic          pkt_clr;
  logic          tmo;

  frame_mon #(.PKT_BITS(PKT_BITS)) u_mon (
    .clk       (clk),
    .rst       (rst),
    .sen       (sen),
    .sd        (sd),
    .sen_idle  (sen_idle),
    .sen_edge  (sen_edge),
    .len_ok    (len_ok),
    .len_short (len_short),
    .len_long  (len_long),
    .addr      (addr)
  );

  assign tmo = (tmr == TMR_MAX) && !sen_edge;

  always_comb begin
    state_nxt  = state;
    code_nxt   = err_code;
    updown_nxt = updown;
    pkt_inc    = 1'b0;
    pkt_clr    = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt  = DOWN;
          code_nxt   = ERR_NONE;
          updown_nxt = 1'b0;
          pkt_clr    = 1'b1;
        end
      end
      DOWN, UP: begin
        // Length faults win over address faults on the same edge.
        if (len_short || len_long) begin
          state_nxt = ERR;
          code_nxt  = ERR_LEN;
        end else if (len_ok && (addr != pkt_cnt[2:0])) begin
          state_nxt = ERR;
          code_nxt  = ERR_ADDR;
        end else if (len_ok) begin
          pkt_inc = (pkt_cnt != PKTS_L);
          if (pkt_cnt == PKTS_L - 4'd1) begin
            if (state == DOWN) state_nxt = TURN;
            else               state_nxt = WAIT_WB;
          end
        end else if (tmo) begin
          state_nxt = ERR;
          code_nxt  = ERR_TMO;
        end
      end
      TURN: begin
        if (sen_idle && turn_idle) begin
          state_nxt  = UP;
          updown_nxt = 1'b1;
          pkt_clr    = 1'b1;
        end else if (tmo) begin
          state_nxt = ERR;
          code_nxt  = ERR_TMO;
        end
      end
      WAIT_WB: begin
        if (s1_done) begin
          state_nxt = DONE;
        end else if (tmo) begin
          state_nxt = ERR;
          code_nxt  = ERR_TMO;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      updown    <= 1'b0;
      err_code  <= ERR_NONE;
      pkt_cnt   <= '0;
      last_addr <= '0;
      tmr       <= '0;
      turn_idle <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_code  <= code_nxt;
      updown    <= updown_nxt;
      turn_idle <= (state == TURN) && sen_idle;
      if ((state_nxt != state) || sen_edge) tmr <= '0;
      else if (tmr != TMR_MAX)              tmr <= tmr + 1'b1;
      if (pkt_clr) begin
        pkt_cnt <= '0;
      end else if (pkt_inc) begin
        pkt_cnt   <= pkt_cnt + 4'd1;
        last_addr <= addr;
      end
    end
  end

  assign busy = (state == DOWN) || (state == TURN) || (state == UP) || (state == WAIT_WB);
  assign done = (state == DONE);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_link_sched.sv
// Randomized bench for link_sched with a frame-level reference model.
module tb_link_sched;

  localparam int PB = 21;
  localparam int NP = 8;
  localparam int TO = 1024;

  localparam int M_IDLE = 0, M_DOWN = 1, M_TURN = 2, M_UP = 3,
                 M_WB = 4, M_DONE = 5, M_ERR = 6;

  logic       clk = 1'b0;
  logic       rst, start, sen, sd, s1_done;
  logic       updown, busy, done, err;
  logic [1:0] err_code;
  logic [3:0] pkt_cnt;
  logic [2:0] last_addr;

  int errors = 0;
  int checks = 0;

  link_sched #(.PKT_BITS(PB), .PKTS(NP), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sen       (sen),
    .sd        (sd),
    .s1_done   (s1_done),
    .updown    (updown),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .pkt_cnt   (pkt_cnt),
    .last_addr (last_addr)
  );

  always #5 clk = ~clk;

  // Reference model: phase, outputs, current low-run length and address,
  // cycles since last activity, idle samples seen while turning around.
  int m_ph, m_code, m_pkts, m_last, run, abits, quiet, tidle;
  bit m_ud, prev_low, armed = 1'b0;

  task automatic model_step();
    bit low, act, fend;
    int nph;
    if (rst) begin
      m_ph = M_IDLE; m_ud = 0; m_code = 0; m_pkts = 0; m_last = 0;
      run = 0; abits = 0; prev_low = 0; quiet = 0; tidle = 0; armed = 1;
      return;
    end
    low  = (sen === 1'b0);
    act  = (low != prev_low);
    fend = prev_low && !low;
    nph  = m_ph;
    if (m_ph != M_TURN) tidle = 0;
    case (m_ph)
      M_IDLE, M_DONE, M_ERR:
        if (start) begin nph = M_DOWN; m_code = 0; m_pkts = 0; m_ud = 0; end
      M_DOWN, M_UP: begin
        if ((low && run == PB) || (fend && run < PB)) begin
          nph = M_ERR; m_code = 1;
        end else if (fend) begin
          if (abits != m_pkts % 8) begin
            nph = M_ERR; m_code = 2;
          end else begin
            m_pkts++; m_last = abits;
            if (m_pkts == NP) nph = (m_ph == M_DOWN) ? M_TURN : M_WB;
          end
        end else if (!act && quiet == TO - 1) begin
          nph = M_ERR; m_code = 3;
        end
      end
      M_TURN: begin
        tidle = low ? 0 : tidle + 1;
        if (tidle >= 2) begin nph = M_UP; m_ud = 1; m_pkts = 0; tidle = 0; end
        else if (!act && quiet == TO - 1) begin nph = M_ERR; m_code = 3; end
      end
      M_WB: begin
        if (s1_done) nph = M_DONE;
        else if (!act && quiet == TO - 1) begin nph = M_ERR; m_code = 3; end
      end
      default: nph = M_IDLE;
    endcase
    quiet = (nph != m_ph || act) ? 0 : quiet + 1;
    if (low) begin
      if (run < 3) abits = ((abits << 1) | int'(sd)) & 7;
      run++;
    end else begin
      run = 0;
    end
    prev_low = low;
    m_ph = nph;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [12:0] got, exp;
    if (armed) begin
      got = {updown, busy, done, err, err_code, pkt_cnt, last_addr};
      exp = {m_ud, (m_ph >= M_DOWN && m_ph <= M_WB), (m_ph == M_DONE), (m_ph == M_ERR),
             2'(m_code), 4'(m_pkts), 3'(m_last)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got ud/bz/dn/er/code/pkt/addr=%b want=%b", $time, got, exp);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic gap(input int n);
    sen = 1'b1;
    for (int i = 0; i < n; i++) begin sd = 1'($urandom); tick(); end
  endtask

  task automatic frame(input int a, input int len, input bit poke);
    for (int i = 0; i < len; i++) begin
      sen   = 1'b0;
      sd    = (i < 3) ? 1'(a >> (2 - i)) : 1'($urandom);
      start = poke && (i == len / 2);
      tick();
    end
    start = 1'b0; sen = 1'b1; sd = 1'($urandom);
    tick();
  endtask

  task automatic wait_flag(input string name, input bit use_done, input int max);
    int n = 0;
    while (((use_done ? done : updown) !== 1'b1) && n < max) begin tick(); n++; end
    checks++;
    if ((use_done ? done : updown) !== 1'b1) begin
      errors++;
      $display("FAIL %s got=0 want=1 within %0d cycles", name, max);
    end
  endtask

  task automatic full_exchange(input bit pokes);
    pulse_start();
    for (int p = 0; p < NP; p++) begin frame(p, PB, pokes); gap($urandom_range(1, 4)); end
    wait_flag("wait_updown", 1'b0, 20);
    for (int p = 0; p < NP; p++) begin frame(p, PB, pokes); gap($urandom_range(1, 4)); end
    s1_done = 1'b1; tick(); s1_done = 1'b0;
    wait_flag("wait_done", 1'b1, 5);
  endtask

  task automatic check_done(input string tag);
    lit({tag, "_done"}, int'(done), 1);
    lit({tag, "_busy"}, int'(busy), 0);
    lit({tag, "_err"}, int'(err), 0);
    lit({tag, "_pkt"}, int'(pkt_cnt), 8);
    lit({tag, "_last"}, int'(last_addr), 7);
    lit({tag, "_updown"}, int'(updown), 1);
    lit({tag, "_model_pkt"}, m_pkts, 8);
  endtask

  task automatic check_reset(input string tag);
    lit({tag, "_outs"}, int'({updown, busy, done, err, err_code, pkt_cnt, last_addr}), 0);
    lit({tag, "_model_ph"}, m_ph, M_IDLE);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sen = 1'b1; sd = 1'b0; s1_done = 1'b0;
    tick(); tick(); tick();
    check_reset("reset");
    rst = 1'b0; tick();

    // Full exchange, with ignored start pulses inside DOWN and UP frames.
    full_exchange(1'b1);
    check_done("exch");

    // Short third frame.
    pulse_start();
    lit("restart_busy", int'(busy), 1);
    lit("restart_done", int'(done), 0);
    lit("restart_pkt", int'(pkt_cnt), 0);
    frame(0, PB, 0); gap(2); frame(1, PB, 0); gap(2); frame(2, PB - 1, 0); gap(2);
    lit("short_err", int'(err), 1);
    lit("short_code", int'(err_code), 1);
    lit("short_busy", int'(busy), 0);
    lit("short_pkt", int'(pkt_cnt), 2);
    lit("short_model_code", m_code, 1);

    // Out-of-order address.
    pulse_start();
    frame(0, PB, 0); gap(2); frame(1, PB, 0); gap(2); frame(3, PB, 0); gap(2);
    lit("addr_err", int'(err), 1);
    lit("addr_code", int'(err_code), 2);
    lit("addr_last", int'(last_addr), 1);
    lit("addr_pkt", int'(pkt_cnt), 2);

    // Idle timeout: ERR lands exactly TIMEOUT edges after start.
    pulse_start();
    gap(TO - 1);
    lit("tmo_before", int'(err), 0);
    gap(1);
    lit("tmo_err", int'(err), 1);
    lit("tmo_code", int'(err_code), 3);
    pulse_start();
    lit("tmo_restart_busy", int'(busy), 1);
    lit("tmo_restart_err", int'(err), 0);

    // Reset mid-frame on low cycle 10 of the fifth frame.
    for (int p = 0; p < 4; p++) begin frame(p, PB, 0); gap(2); end
    sen = 1'b0;
    for (int i = 0; i < 9; i++) begin sd = (i < 3) ? 1'(4 >> (2 - i)) : 1'($urandom); tick(); end
    rst = 1'b1; tick();
    check_reset("midrst");
    rst = 1'b0; sen = 1'b1; tick();
    check_reset("midrst_after");
    full_exchange(1'b0);
    check_done("exch2");

    // Long frame: 22nd low cycle aborts.
    pulse_start();
    frame(0, PB + 1, 0); gap(2);
    lit("long_code", int'(err_code), 1);
    lit("long_pkt", int'(pkt_cnt), 0);

    // Short frame with a wrong address reports a length fault.
    pulse_start();
    frame(0, PB, 0); gap(2); frame(5, PB - 1, 0); gap(2);
    lit("both_code", int'(err_code), 1);
    lit("both_pkt", int'(pkt_cnt), 1);

    // Randomized exchanges steered by the model's view of the phase.
    for (int it = 0; it < 25; it++) begin
      pulse_start();
      for (int f = 0; f < 60 && !(m_ph == M_ERR || m_ph == M_DONE); f++) begin
        if (m_ph == M_TURN) begin
          gap(1);
        end else if (m_ph == M_WB) begin
          gap($urandom_range(0, 4));
          s1_done = 1'b1; tick(); gap($urandom_range(0, 2)); s1_done = 1'b0;
        end else begin
          int a, r, len;
          a   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : (m_pkts % 8);
          r   = $urandom_range(0, 19);
          len = (r == 0) ? PB - 1 : (r == 1) ? PB + 1 : PB;
          frame(a, len, $urandom_range(0, 3) == 0);
          gap($urandom_range(1, 3));
        end
      end
      gap(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
